// File: rtl/pwm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pwm_pkg : shared slot timing, duty-code width and decoder FSM states
// Revision: 1.0
// ------------------------------------------------------------------
package pwm_pkg;

  localparam int SLOT_CYCLES    = 16;
  localparam int SLOTS          = 16;
  localparam int NOMINAL_PERIOD = SLOT_CYCLES * SLOTS;
  localparam int DUTY_W         = 4;
  localparam int CNT_W          = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_decoder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pwm_duty_decoder_if : PWM line in, decoded duty code and status out
// Revision: 1.0
// ------------------------------------------------------------------
interface pwm_duty_decoder_if;
  import pwm_pkg::*;

  logic              pwm_in;
  logic [DUTY_W-1:0] duty_cycle;
  logic              duty_valid;
  logic              period_err;
  logic              stuck_high;

  // master drives the line and observes the decode; slave is the decoder
  modport master (
    output pwm_in,
    input  duty_cycle, duty_valid, period_err, stuck_high
  );

  modport slave (
    input  pwm_in,
    output duty_cycle, duty_valid, period_err, stuck_high
  );

endinterface
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_edge_detect : 2-flop synchronizer with rise/fall strobes
// Revision: 1.0
// ------------------------------------------------------------------
module sync_edge_detect (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  din,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;
  assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// pwm_duty_decoder : measures PWM high time and period, recovers duty
// Revision: 1.0
// ------------------------------------------------------------------
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int PER_TOL = 4,
  parameter int TIMEOUT = 512
) (
  input wire               clk_50M,
  input wire               rst_n,
  pwm_duty_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   PER_MIN  = (CNT_W+1)'(NOMINAL_PERIOD - PER_TOL);
  localparam logic [CNT_W:0]   PER_MAX  = (CNT_W+1)'(NOMINAL_PERIOD + PER_TOL);
  localparam logic [CNT_W:0]   HALF     = (CNT_W+1)'(SLOT_CYCLES / 2);
  localparam logic [CNT_W:0]   DUTY_MAX = (CNT_W+1)'((1 << DUTY_W) - 1);
  localparam int               SLOT_SHIFT = $clog2(SLOT_CYCLES);

  logic w_rise, w_fall;

  sync_edge_detect u_sync (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .din   (bus.pwm_in),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  dec_state_t        r_state, w_state_next;
  logic [CNT_W-1:0]  r_hi_cnt, w_hi_next, w_hi_inc;
  logic [CNT_W-1:0]  r_lo_cnt, w_lo_next, w_lo_inc;
  logic [DUTY_W-1:0] r_duty, w_duty_next, w_code;
  logic              r_valid, w_valid_next;
  logic              r_perr, w_perr_next;
  logic              r_stuck, w_stuck_next;
  logic [CNT_W:0]    w_per, w_round, w_quot;
  logic              w_per_ok;

  assign w_hi_inc = (r_hi_cnt == CNT_MAX) ? r_hi_cnt : r_hi_cnt + 1'b1;
  assign w_lo_inc = (r_lo_cnt == CNT_MAX) ? r_lo_cnt : r_lo_cnt + 1'b1;

  // The rising-edge cycle itself belongs to the low phase, hence w_lo_inc.
  assign w_per    = {1'b0, r_hi_cnt} + {1'b0, w_lo_inc};
  assign w_per_ok = (w_per >= PER_MIN) && (w_per <= PER_MAX);
  assign w_round  = {1'b0, r_hi_cnt} + HALF;
  assign w_quot   = w_round >> SLOT_SHIFT;
  assign w_code   = (w_quot > DUTY_MAX) ? DUTY_MAX[DUTY_W-1:0] : w_quot[DUTY_W-1:0];

  always_comb begin
    w_state_next = r_state;
    w_hi_next    = r_hi_cnt;
    w_lo_next    = r_lo_cnt;
    w_duty_next  = r_duty;
    w_valid_next = 1'b0;
    w_perr_next  = r_perr;
    w_stuck_next = r_stuck;
    unique case (r_state)
      IDLE: begin
        if (w_fall) w_stuck_next = 1'b0;
        if (w_rise) begin
          w_hi_next    = '0;
          w_state_next = HIGH;
        end
      end
      HIGH: begin
        w_hi_next = w_hi_inc;
        if (w_fall) begin
          w_lo_next    = '0;
          w_state_next = LOW;
        end else if (w_hi_inc == TO_CNT) begin
          w_stuck_next = 1'b1;
          w_state_next = IDLE;
        end
      end
      LOW: begin
        w_lo_next = w_lo_inc;
        if (w_rise) begin
          if (w_per_ok) begin
            w_duty_next  = w_code;
            w_valid_next = 1'b1;
          end else begin
            w_perr_next = 1'b1;
          end
          w_hi_next    = '0;
          w_state_next = HIGH;
        end else if (w_lo_inc == TO_CNT) begin
          // A line parked low reads as 0 % duty, reported once.
          w_duty_next  = '0;
          w_valid_next = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
      r_duty   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_stuck  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_hi_cnt <= w_hi_next;
      r_lo_cnt <= w_lo_next;
      r_duty   <= w_duty_next;
      r_valid  <= w_valid_next;
      r_perr   <= w_perr_next;
      r_stuck  <= w_stuck_next;
    end
  end

  assign bus.duty_cycle = r_duty;
  assign bus.duty_valid = r_valid;
  assign bus.period_err = r_perr;
  assign bus.stuck_high = r_stuck;

endmodule
`default_nettype wire
